lfsr_checker: RTL and testbench

LFSR_CHECKER -- requirements
Module: lfsr_checker

---
 rtl/lfsr_checker.sv | 148 ++++++++++++++
 tb/tb_lfsr_checker.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Locks onto an 8-bit LFSR stream (fb = s0^s2^s3^s4, shift right) and counts word errors once locked.
// Optional per-bit error counting when LFSR_CHK_BITERR_EN is defined.
module lfsr_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        clr_cnt,
  output logic        locked,
  output logic        err,
  output logic [15:0] err_cnt,
  output logic [15:0] word_cnt,
  output logic [15:0] bit_err_cnt
);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[4], s[7:1]};
  endfunction

  state_t      state, state_nxt;
  logic [7:0]  pred, pred_nxt;
  logic [3:0]  match_run, match_run_nxt;
  logic [3:0]  miss_run, miss_run_nxt;
  logic        err_nxt;
  logic        cnt_word;
  logic        cnt_err;
  logic        match;

  assign match = (in_data == pred);

  always_comb begin
    state_nxt     = state;
    pred_nxt      = pred;
    match_run_nxt = match_run;
    miss_run_nxt  = miss_run;
    err_nxt       = 1'b0;
    cnt_word      = 1'b0;
    cnt_err       = 1'b0;
    if (in_valid) begin
      case (state)
        HUNT: begin
          if (in_data != 8'h00) begin
            pred_nxt      = lfsr_next(in_data);
            match_run_nxt = 4'd0;
            state_nxt     = VERIFY;
          end
        end
        VERIFY: begin
          if (match) begin
            match_run_nxt = match_run + 4'd1;
            pred_nxt      = lfsr_next(in_data);
            if (match_run_nxt == LOCK_N) begin
              state_nxt    = LOCKED;
              miss_run_nxt = 4'd0;
            end
          end else if (in_data != 8'h00) begin
            pred_nxt      = lfsr_next(in_data);
            match_run_nxt = 4'd0;
          end else begin
            state_nxt     = HUNT;
            match_run_nxt = 4'd0;
          end
        end
        LOCKED: begin
          // Predictor free-runs; the input is only compared, never used as a seed.
          pred_nxt = lfsr_next(pred);
          cnt_word = 1'b1;
          if (match) begin
            miss_run_nxt = 4'd0;
          end else if (miss_run + 4'd1 == LOSS_N) begin
            state_nxt     = HUNT;
            miss_run_nxt  = 4'd0;
            match_run_nxt = 4'd0;
          end else begin
            miss_run_nxt = miss_run + 4'd1;
            err_nxt      = 1'b1;
            cnt_err      = 1'b1;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      pred      <= 8'h00;
      match_run <= 4'd0;
      miss_run  <= 4'd0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= 16'h0000;
      word_cnt  <= 16'h0000;
    end else begin
      state     <= state_nxt;
      pred      <= pred_nxt;
      match_run <= match_run_nxt;
      miss_run  <= miss_run_nxt;
      locked    <= (state_nxt == LOCKED);
      err       <= err_nxt;
      // Clear takes priority over a coincident increment.
      if (clr_cnt) begin
        err_cnt  <= 16'h0000;
        word_cnt <= 16'h0000;
      end else begin
        if (cnt_err && err_cnt != 16'hFFFF)
          err_cnt <= err_cnt + 16'd1;
        if (cnt_word && word_cnt != 16'hFFFF)
          word_cnt <= word_cnt + 16'd1;
      end
    end
  end

`ifdef LFSR_CHK_BITERR_EN
  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++)
      n = n + {3'd0, v[i]};
    return n;
  endfunction

  logic [16:0] bit_sum;
  logic [15:0] bit_err_q;

  assign bit_sum     = {1'b0, bit_err_q} + {13'd0, popcnt8(in_data ^ pred)};
  assign bit_err_cnt = bit_err_q;

  always_ff @(posedge clk) begin
    if (rst || clr_cnt)
      bit_err_q <= 16'h0000;
    else if (cnt_err)
      bit_err_q <= bit_sum[16] ? 16'hFFFF : bit_sum[15:0];
  end
`else
  assign bit_err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock, error pulses, loss, HUNT/VERIFY zero handling, clear and reset.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        clr_cnt;
  logic        locked;
  logic        err;
  logic [15:0] err_cnt;
  logic [15:0] word_cnt;
  logic [15:0] bit_err_cnt;

  int checks   = 0;
  int failures = 0;

  lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .clr_cnt     (clr_cnt),
    .locked      (locked),
    .err         (err),
    .err_cnt     (err_cnt),
    .word_cnt    (word_cnt),
    .bit_err_cnt (bit_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic v, input logic [7:0] d, input logic c);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    in_data  = d;
    clr_cnt  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [15:0] bexp(input logic [15:0] v);
`ifdef LFSR_CHK_BITERR_EN
    return v;
`else
    return 16'h0000 & v;
`endif
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; clr_cnt = 1'b0;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h01, 1'b1);
    check("rst_locked",  {15'd0, locked}, 16'd0);
    check("rst_err",     {15'd0, err},    16'd0);
    check("rst_err_cnt", err_cnt,         16'd0);
    check("rst_word_cnt", word_cnt,       16'd0);
    check("rst_bit_cnt", bit_err_cnt,     16'd0);

    // Acquire lock: seed + LOCK_CNT matches.
    step(1'b0, 1'b1, 8'h01, 1'b0);
    step(1'b0, 1'b1, 8'h80, 1'b0);
    step(1'b0, 1'b1, 8'h40, 1'b0);
    step(1'b0, 1'b1, 8'h20, 1'b0);
    check("lock_early",  {15'd0, locked}, 16'd0);
    step(1'b0, 1'b1, 8'h10, 1'b0);
    check("lock_rise",   {15'd0, locked}, 16'd1);
    check("lock_err",    {15'd0, err},    16'd0);
    check("lock_err_cnt", err_cnt,        16'd0);

    // Single-bit error against predicted 0x88, idle gap, then on-sequence 0xC4.
    step(1'b0, 1'b1, 8'h89, 1'b0);
    check("e1_err",      {15'd0, err},    16'd1);
    check("e1_err_cnt",  err_cnt,         16'd1);
    check("e1_word_cnt", word_cnt,        16'd1);
    step(1'b0, 1'b0, 8'h55, 1'b0);
    check("idle_err",    {15'd0, err},    16'd0);
    check("idle_err_cnt", err_cnt,        16'd1);
    step(1'b0, 1'b1, 8'hC4, 1'b0);
    check("e1b_err",     {15'd0, err},    16'd0);
    check("e1b_err_cnt", err_cnt,         16'd1);
    check("e1b_word_cnt", word_cnt,       16'd2);
    check("e1b_bit_cnt", bit_err_cnt,     bexp(16'd1));
    check("e1b_locked",  {15'd0, locked}, 16'd1);

    // Three misses against predicted 0xE2, 0x71, 0x38: loss on the third.
    step(1'b0, 1'b1, 8'h00, 1'b0);
    check("m1_err",      {15'd0, err},    16'd1);
    check("m1_err_cnt",  err_cnt,         16'd2);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    check("m2_err",      {15'd0, err},    16'd1);
    check("m2_err_cnt",  err_cnt,         16'd3);
    check("m2_locked",   {15'd0, locked}, 16'd1);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    check("m3_err",      {15'd0, err},    16'd0);
    check("m3_err_cnt",  err_cnt,         16'd3);
    check("m3_locked",   {15'd0, locked}, 16'd0);
    check("m3_bit_cnt",  bit_err_cnt,     bexp(16'd9));

    // HUNT ignores zeros; zero in VERIFY drops back to HUNT.
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h01, 1'b0);
    step(1'b0, 1'b1, 8'h80, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    check("z_locked",    {15'd0, locked}, 16'd0);
    check("z_err_cnt",   err_cnt,         16'd3);
    step(1'b0, 1'b1, 8'h40, 1'b0);
    step(1'b0, 1'b1, 8'h20, 1'b0);
    step(1'b0, 1'b1, 8'h10, 1'b0);
    step(1'b0, 1'b1, 8'h88, 1'b0);
    check("z_relock_early", {15'd0, locked}, 16'd0);
    step(1'b0, 1'b1, 8'hC4, 1'b0);
    check("z_relock",    {15'd0, locked}, 16'd1);

    // Alternating miss/match keeps lock; err_cnt reaches 5.
    step(1'b0, 1'b1, 8'hE3, 1'b0);
    check("a1_err",      {15'd0, err},    16'd1);
    check("a1_err_cnt",  err_cnt,         16'd4);
    step(1'b0, 1'b1, 8'h71, 1'b0);
    check("a2_err",      {15'd0, err},    16'd0);
    step(1'b0, 1'b1, 8'h39, 1'b0);
    check("a3_err_cnt",  err_cnt,         16'd5);
    step(1'b0, 1'b1, 8'h1C, 1'b0);
    check("a4_locked",   {15'd0, locked}, 16'd1);
    check("a4_err_cnt",  err_cnt,         16'd5);
    check("a4_bit_cnt",  bit_err_cnt,     bexp(16'd11));

    // Clear coincident with a miss (predicted 0x8E).
    step(1'b0, 1'b1, 8'h00, 1'b1);
    check("clr_err",     {15'd0, err},    16'd1);
    check("clr_err_cnt", err_cnt,         16'd0);
    check("clr_word_cnt", word_cnt,       16'd0);
    check("clr_bit_cnt", bit_err_cnt,     16'd0);
    check("clr_locked",  {15'd0, locked}, 16'd1);

    // Reset while locked with a valid word present.
    step(1'b1, 1'b1, 8'h47, 1'b0);
    check("r2_locked",   {15'd0, locked}, 16'd0);
    check("r2_err",      {15'd0, err},    16'd0);
    check("r2_err_cnt",  err_cnt,         16'd0);
    check("r2_word_cnt", word_cnt,        16'd0);
    step(1'b0, 1'b1, 8'h01, 1'b0);
    step(1'b0, 1'b1, 8'h80, 1'b0);
    step(1'b0, 1'b1, 8'h40, 1'b0);
    step(1'b0, 1'b1, 8'h20, 1'b0);
    check("r2_relock_early", {15'd0, locked}, 16'd0);
    step(1'b0, 1'b1, 8'h10, 1'b0);
    check("r2_relock",   {15'd0, locked}, 16'd1);
    step(1'b0, 1'b1, 8'h88, 1'b0);
    check("r2_match_err", {15'd0, err},   16'd0);
    check("r2_word_cnt1", word_cnt,       16'd1);

    step(1'b0, 1'b0, 8'h00, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
